// File: rtl/ps2_scancode_rx_fifo.sv
// PS/2 device-to-host receiver: pin filtering, frame deframing with parity/stop checks,
// E0/F0 prefix merging into key events, and a first-word-fall-through event FIFO.
module ps2_scancode_rx_fifo #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DEPTH          = 8,
  parameter bit RAW_MODE       = 1'b0,
  parameter bit CHECK_STOP     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2c,
  input  logic                     ps2d,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_brk,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic [7:0]               curr_code,
  output logic [7:0]               prev_code,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  // Stage: two-flop synchronisers and glitch filters (bus idles high)
  logic c_sync_p0, c_sync_p1, d_sync_p0, d_sync_p1;
  logic c_filt, d_filt, c_filt_q;
  logic [FW-1:0] c_cnt, d_cnt;
  logic fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync_p0 <= 1'b1;
      c_sync_p1 <= 1'b1;
      d_sync_p0 <= 1'b1;
      d_sync_p1 <= 1'b1;
      c_filt    <= 1'b1;
      d_filt    <= 1'b1;
      c_filt_q  <= 1'b1;
      c_cnt     <= '0;
      d_cnt     <= '0;
    end else begin
      c_sync_p0 <= ps2c;
      c_sync_p1 <= c_sync_p0;
      d_sync_p0 <= ps2d;
      d_sync_p1 <= d_sync_p0;
      c_filt_q  <= c_filt;
      if (c_sync_p1 == c_filt) c_cnt <= '0;
      else if (c_cnt == FILT_MAX) begin
        c_filt <= c_sync_p1;
        c_cnt  <= '0;
      end else c_cnt <= c_cnt + FW'(1);
      if (d_sync_p1 == d_filt) d_cnt <= '0;
      else if (d_cnt == FILT_MAX) begin
        d_filt <= d_sync_p1;
        d_cnt  <= '0;
      end else d_cnt <= d_cnt + FW'(1);
    end
  end

  assign fall = c_filt_q & ~c_filt;

  // Stage: frame FSM
  state_t state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic par, par_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic ok_nx, perr_nx, ferr_nx;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    ok_nx      = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;
    tmo_nx     = (state == IDLE || fall) ? '0 : tmo + TW'(1);
    case (state)
      IDLE: if (fall && !d_filt) begin
        state_nx   = DATA;
        bit_cnt_nx = 3'd0;
      end
      DATA: if (fall) begin
        shreg_nx   = {d_filt, shreg[7:1]};
        bit_cnt_nx = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nx = PARITY;
      end
      PARITY: if (fall) begin
        par_nx   = d_filt;
        state_nx = STOP;
      end
      STOP: if (fall) begin
        state_nx = IDLE;
        if (!parity_ok(shreg, par)) perr_nx = 1'b1;
        else if (CHECK_STOP && !d_filt) ferr_nx = 1'b1;
        else ok_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // A stalled clock mid-frame abandons the partial byte
    if (state != IDLE && !fall && tmo == TMO_MAX) begin
      state_nx = IDLE;
      ferr_nx  = 1'b1;
      ok_nx    = 1'b0;
      tmo_nx   = '0;
    end
  end

  // Stage p0: completed byte and error pulses
  logic vld_p0, perr_p0, ferr_p0;
  logic [7:0] byte_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      tmo     <= '0;
      vld_p0  <= 1'b0;
      perr_p0 <= 1'b0;
      ferr_p0 <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      tmo     <= tmo_nx;
      vld_p0  <= ok_nx;
      perr_p0 <= perr_nx;
      ferr_p0 <= ferr_nx;
    end
  end

  always_ff @(posedge clk) begin
    shreg   <= shreg_nx;
    par     <= par_nx;
    byte_p0 <= shreg;
  end

  // Stage p1: prefix merge and FIFO push
  logic ext_pend, brk_pend, ext_nx, brk_nx;
  logic push_req;
  logic [9:0] push_ev;

  always_comb begin
    ext_nx   = ext_pend;
    brk_nx   = brk_pend;
    push_req = 1'b0;
    push_ev  = {ext_pend, brk_pend, byte_p0};
    if (perr_p0 || ferr_p0) begin
      ext_nx = 1'b0;
      brk_nx = 1'b0;
    end else if (vld_p0) begin
      if (RAW_MODE) begin
        push_req = 1'b1;
        push_ev  = {2'b00, byte_p0};
      end else if (byte_p0 == 8'hE0) ext_nx = 1'b1;
      else if (byte_p0 == 8'hF0) brk_nx = 1'b1;
      else begin
        push_req = 1'b1;
        ext_nx   = 1'b0;
        brk_nx   = 1'b0;
      end
    end
  end

  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, pop, do_push;
  logic [9:0] head;

  assign full    = (count == CW'(DEPTH));
  assign pop     = ev_valid & ev_ready;
  assign do_push = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      curr_code <= 8'h00;
      prev_code <= 8'h00;
    end else begin
      ext_pend <= ext_nx;
      brk_pend <= brk_nx;
      overflow <= push_req & full & ~pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Make codes track the display even when the FIFO drops the event
      if (push_req && !push_ev[8]) begin
        prev_code <= curr_code;
        curr_code <= push_ev[7:0];
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_valid   = (count != '0);
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign ev_brk     = ev_valid & head[8];
  assign ev_ext     = ev_valid & head[9];
  assign ev_count   = count;
  assign parity_err = perr_p0;
  assign frame_err  = ferr_p0;

endmodule

// File: tb/tb_ps2_scancode_rx_fifo.sv
// Bench for ps2_scancode_rx_fifo: bit-banged PS/2 frames, event scoreboard, error/overflow pulse counts.
module tb_ps2_scancode_rx_fifo;

  localparam int HALF = 20;
  localparam int TMO  = 2000;
  localparam int DEP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  logic ev_ready = 1'b0;
  logic ev_valid, ev_ext, ev_brk, parity_err, frame_err, overflow;
  logic [7:0] ev_code, curr_code, prev_code;
  logic [$clog2(DEP):0] ev_count;

  logic ready2 = 1'b1;
  logic ev_valid2, ev_ext2, ev_brk2, parity_err2, frame_err2, overflow2;
  logic [7:0] ev_code2, curr_code2, prev_code2;
  logic [3:0] ev_count2;

  int n_checks = 0;
  int n_fail = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_scancode_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .DEPTH(DEP),
    .RAW_MODE(1'b0), .CHECK_STOP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_brk(ev_brk), .ev_count(ev_count), .curr_code(curr_code), .prev_code(prev_code),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow));

  ps2_scancode_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .DEPTH(8),
    .RAW_MODE(1'b0), .CHECK_STOP(1'b0)) u_nostop (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
    .ev_valid(ev_valid2), .ev_ready(ready2), .ev_code(ev_code2), .ev_ext(ev_ext2),
    .ev_brk(ev_brk2), .ev_count(ev_count2), .curr_code(curr_code2), .prev_code(prev_code2),
    .parity_err(parity_err2), .frame_err(frame_err2), .overflow(overflow2));

  // Scoreboard: every accepted head must match the oldest expected event
  always @(negedge clk) begin
    if (!rst) begin
      if (parity_err) perr_cnt++;
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (ev_valid && ev_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_pop got ext=%0b brk=%0b code=%h expected no event", ev_ext, ev_brk, ev_code);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({ev_ext, ev_brk, ev_code} !== e) begin
            n_fail++;
            $display("FAIL event_pop got ext=%0b brk=%0b code=%h expected ext=%0b brk=%0b code=%h",
                     ev_ext, ev_brk, ev_code, e[9], e[8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      wait_cyc(HALF);
      ps2c = 1'b0;
      wait_cyc(HALF);
      ps2c = 1'b1;
    end
    if (nbits == 11) begin
      wait_cyc(HALF / 2);
      ps2d = 1'b1;
      wait_cyc(2 * HALF);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic wait_empty(input int lim);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    wait_cyc(4);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cyc(5);
    #1 rst = 1'b0;
    wait_cyc(3);
    #1;
    n_checks++;
    if ({ev_valid, ev_ext, ev_brk, ev_code} !== 11'd0) begin
      n_fail++; $display("FAIL reset_head got %b expected 0", {ev_valid, ev_ext, ev_brk, ev_code});
    end
    n_checks++;
    if (ev_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", ev_count); end
    n_checks++;
    if ({curr_code, prev_code} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_codes got %h expected 0000", {curr_code, prev_code});
    end
    n_checks++;
    if ({parity_err, frame_err, overflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got %b expected 000", {parity_err, frame_err, overflow});
    end
  endtask

  task automatic test_ext_prefix;
    exp_q.push_back({2'b10, 8'h72});
    exp_q.push_back({2'b11, 8'h72});
    send_byte(8'hE0); send_byte(8'h72); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
    wait_empty(500);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ext_drain got %0d pending expected 0", exp_q.size()); end
    n_checks++;
    if (curr_code !== 8'h72) begin n_fail++; $display("FAIL ext_curr got %h expected 72", curr_code); end
  endtask

  task automatic test_make_break;
    exp_q.push_back({2'b00, 8'h1C});
    exp_q.push_back({2'b01, 8'h1C});
    exp_q.push_back({2'b00, 8'h32});
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h32);
    wait_empty(500);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mb_drain got %0d pending expected 0", exp_q.size()); end
    n_checks++;
    if ({curr_code, prev_code} !== 16'h321C) begin
      n_fail++; $display("FAIL mb_codes got %h expected 321c", {curr_code, prev_code});
    end
  endtask

  task automatic test_parity;
    int p0, f0;
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    wait_cyc(20);
    #1;
    n_checks++;
    if (perr_cnt - p0 != 1) begin n_fail++; $display("FAIL parity_pulse got %0d expected 1", perr_cnt - p0); end
    n_checks++;
    if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL parity_noframe got %0d expected 0", ferr_cnt - f0); end
    n_checks++;
    if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL parity_noevent got %b expected 0", ev_valid); end
    exp_q.push_back({2'b00, 8'h1B});
    send_byte(8'h1B);
    wait_empty(500);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL parity_next got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow;
    int o0;
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    @(posedge clk); #1 ev_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, codes[i]});
    for (int i = 0; i < 5; i++) send_byte(codes[i]);
    wait_cyc(20);
    #1;
    n_checks++;
    if (ovf_cnt - o0 != 1) begin n_fail++; $display("FAIL ovf_pulse got %0d expected 1", ovf_cnt - o0); end
    n_checks++;
    if (ev_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d expected 4", ev_count); end
    n_checks++;
    if (ev_code !== 8'h15) begin n_fail++; $display("FAIL ovf_head got %h expected 15", ev_code); end
    n_checks++;
    if ({curr_code, prev_code} !== 16'h2C2D) begin
      n_fail++; $display("FAIL ovf_codes got %h expected 2c2d", {curr_code, prev_code});
    end
    @(posedge clk); #1 ev_ready = 1'b1;
    wait_empty(50);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain got %0d pending expected 0", exp_q.size()); end
    n_checks++;
    if (ev_count !== 3'd0) begin n_fail++; $display("FAIL ovf_empty got %0d expected 0", ev_count); end
  endtask

  task automatic test_timeout;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 5);
    ps2d = 1'b1;
    wait_cyc(TMO + 50);
    #1;
    n_checks++;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL timeout_pulse got %0d expected 1", ferr_cnt - f0); end
    exp_q.push_back({2'b00, 8'h23});
    send_byte(8'h23);
    wait_empty(500);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL timeout_next got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    send_byte(8'hE0);
    send_frame(8'h72, 1'b0, 1'b1, 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ps2d = 1'b1;
    wait_cyc(2 * HALF);
    #1;
    n_checks++;
    if (ev_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count got %0d expected 0", ev_count); end
    exp_q.push_back({2'b00, 8'h72});
    send_byte(8'h72);
    wait_empty(500);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_event got %0d pending expected 0", exp_q.size()); end
    n_checks++;
    if (curr_code !== 8'h72) begin n_fail++; $display("FAIL rstmid_curr got %h expected 72", curr_code); end
  endtask

  task automatic test_stop_bit;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h4B, 1'b0, 1'b0, 11);
    wait_cyc(20);
    #1;
    n_checks++;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL stop_pulse got %0d expected 1", ferr_cnt - f0); end
    n_checks++;
    if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL stop_noevent got %b expected 0", ev_valid); end
    n_checks++;
    if (curr_code2 !== 8'h4B) begin n_fail++; $display("FAIL stop_ignored got %h expected 4b", curr_code2); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] c, last;
    last = 8'h00;
    for (int i = 0; i < 6; i++) begin
      c = 8'($urandom_range(1, 127));
      exp_q.push_back({2'b00, c});
      send_byte(c);
      last = c;
    end
    wait_empty(500);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain got %0d pending expected 0", exp_q.size()); end
    n_checks++;
    if (curr_code !== last) begin n_fail++; $display("FAIL b2b_curr got %h expected %h", curr_code, last); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1 ev_ready = 1'b1;
    test_ext_prefix();
    test_make_break();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_stop_bit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
